data_mem_arbiter: RTL and testbench

- Shares the single-port 256x16 data memory between two requesters.
  - Port 0: CPU load/store unit.
  - Port 1: DMA/debug loader.
- Each request is accepted, driven onto the memory's MemRead/MemWrite/DataAddress/DataIn pins from registers, completed and acknowledged.
- Sits between the requesters and the data memory. It is the only driver of the memory control pins.

---
 rtl/data_mem_arbiter_pkg.sv | 15 +
 rtl/data_mem_arbiter_if.sv | 33 +++
 rtl/data_mem_arbiter_rr_arb2.sv | 15 +
 rtl/data_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the two-port data memory arbiter.
// Single-cycle access FSM state encoding and requester port indices.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;
    localparam int DATA_W   = 16;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester (CPU, DMA) and data-memory pins seen by the arbiter.
// slave = arbiter side; master = requesters plus the memory's read data.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              P0_REQ,   P1_REQ;
    logic              P0_WE,    P1_WE;
    logic [ADDR_W-1:0] P0_ADDR,  P1_ADDR;
    logic [15:0]       P0_WDATA, P1_WDATA;
    logic              P0_ACK,   P1_ACK;
    logic [15:0]       P0_RDATA, P1_RDATA;
    logic              P0_ERR,   P1_ERR;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] DataAddress;
    logic [15:0]       DataIn;
    logic [15:0]       MemDataOut;
    logic              BUSY;

    modport slave (
        input  P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADDR, P1_ADDR,
               P0_WDATA, P1_WDATA, MemDataOut,
        output P0_ACK, P1_ACK, P0_RDATA, P1_RDATA, P0_ERR, P1_ERR,
               MemRead, MemWrite, DataAddress, DataIn, BUSY
    );

    modport master (
        output P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADDR, P1_ADDR,
               P0_WDATA, P1_WDATA, MemDataOut,
        input  P0_ACK, P1_ACK, P0_RDATA, P1_RDATA, P0_ERR, P1_ERR,
               MemRead, MemWrite, DataAddress, DataIn, BUSY
    );
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational 2-way grant: a lone request wins; on a tie the port not
// granted last wins, or port 0 always wins when fixed_pri is set.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_pri,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (fixed_pri || last) ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (port 0) and DMA (port 1) onto a single-port data memory.
// Accept in IDLE, one ACCESS cycle, ACK in RESP: ACK two cycles after acceptance, one access per 3 cycles.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int FIXED_PRI  = 0
) (
    input  logic               CLK,
    input  logic               RST_N,
    data_mem_arbiter_if.slave  bus
);
    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          perr_q, perr_d;

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                sel;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                in_range;

    assign req       = {bus.P1_REQ, bus.P0_REQ};
    assign sel       = gnt[PORT_DMA];
    assign sel_we    = sel ? bus.P1_WE    : bus.P0_WE;
    assign sel_addr  = sel ? bus.P1_ADDR  : bus.P0_ADDR;
    assign sel_wdata = sel ? bus.P1_WDATA : bus.P0_WDATA;
    assign in_range  = (sel_addr[ADDR_W-1:DEPTH_LOG2] == '0);

    rr_arb2 u_arb (
        .req       (req),
        .last      (last_q),
        .fixed_pri (FIXED_PRI != 0),
        .gnt       (gnt)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        err_d    = err_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack_d    = ack_q;
        perr_d   = perr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ACCESS;
                    win_d   = sel;
                    last_d  = sel;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    din_d   = sel_wdata;
                    err_d   = ~in_range;
                    // Out-of-range accesses never reach the memory pins.
                    rd_d    = in_range & ~sel_we;
                    wr_d    = in_range &  sel_we;
                end
            end
            ACCESS: begin
                state_d        = RESP;
                rd_d           = 1'b0;
                wr_d           = 1'b0;
                addr_d         = '0;
                din_d          = '0;
                ack_d[win_q]   = 1'b1;
                perr_d[win_q]  = err_q;
                if (!we_q) begin
                    if (win_q) rdata1_d = err_q ? '0 : bus.MemDataOut;
                    else       rdata0_d = err_q ? '0 : bus.MemDataOut;
                end
            end
            RESP: begin
                state_d = IDLE;
                ack_d   = '0;
                perr_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack_q    <= '0;
            perr_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack_q    <= ack_d;
            perr_q   <= perr_d;
        end
    end

    assign bus.MemRead     = rd_q;
    assign bus.MemWrite    = wr_q;
    assign bus.DataAddress = addr_q;
    assign bus.DataIn      = din_q;
    assign bus.P0_ACK      = ack_q[PORT_CPU];
    assign bus.P1_ACK      = ack_q[PORT_DMA];
    assign bus.P0_ERR      = perr_q[PORT_CPU];
    assign bus.P1_ERR      = perr_q[PORT_DMA];
    assign bus.P0_RDATA    = rdata0_q;
    assign bus.P1_RDATA    = rdata1_q;
    assign bus.BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: round-robin instance with a 256x16 memory model, plus a
// fixed-priority instance used only for the starvation check.
module tb_data_mem_arbiter;
    logic CLK;
    logic RST_N;
    int   total;
    int   passed;

    data_mem_arbiter_if #(.ADDR_W(16)) bus ();
    data_mem_arbiter_if #(.ADDR_W(16)) bfx ();

    data_mem_arbiter #(.ADDR_W(16), .DEPTH_LOG2(8), .FIXED_PRI(0)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    data_mem_arbiter #(.ADDR_W(16), .DEPTH_LOG2(8), .FIXED_PRI(1)) dut_fx (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bfx.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: combinational read, write at the posedge while MemWrite is high.
    logic [15:0] mem [256];
    int          wr_cnt;
    int          rd_cnt;
    int          both_hi;

    assign bus.MemDataOut = bus.MemRead ? mem[bus.DataAddress[7:0]] : 16'h0000;
    assign bfx.MemDataOut = bfx.MemRead ? 16'h00AA : 16'h0000;

    always @(posedge CLK) begin
        if (bus.MemWrite) begin
            mem[bus.DataAddress[7:0]] <= bus.DataIn;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.MemRead) rd_cnt <= rd_cnt + 1;
        if ((bus.MemRead && bus.MemWrite) || (bfx.MemRead && bfx.MemWrite))
            both_hi <= both_hi + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [1:0] rr_exp [4];
        int         ack_t [$];
        int         n0, n1;

        total = 0; passed = 0;
        wr_cnt = 0; rd_cnt = 0; both_hi = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'd7;
        mem[9] = 16'd15;
        rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

        bus.P0_REQ = 0; bus.P1_REQ = 0; bus.P0_WE = 0; bus.P1_WE = 0;
        bus.P0_ADDR = 0; bus.P1_ADDR = 0; bus.P0_WDATA = 0; bus.P1_WDATA = 0;
        bfx.P0_REQ = 0; bfx.P1_REQ = 0; bfx.P0_WE = 0; bfx.P1_WE = 0;
        bfx.P0_ADDR = 0; bfx.P1_ADDR = 0; bfx.P0_WDATA = 0; bfx.P1_WDATA = 0;

        RST_N = 1'b0;
        #1;
        chk("rst_memread",  bus.MemRead, 0);
        chk("rst_memwrite", bus.MemWrite, 0);
        chk("rst_addr",     bus.DataAddress, 0);
        chk("rst_busy",     bus.BUSY, 0);
        chk("rst_ack",      {bus.P1_ACK, bus.P0_ACK}, 0);
        chk("rst_rdata0",   bus.P0_RDATA, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // P0 reads addr 0; REQ dropped early, access still completes.
        bus.P0_REQ = 1; bus.P0_WE = 0; bus.P0_ADDR = 16'd0;
        tick();
        chk("rd0_busy",    bus.BUSY, 1);
        chk("rd0_memread", bus.MemRead, 1);
        chk("rd0_ack_early", bus.P0_ACK, 0);
        bus.P0_REQ = 0;
        tick();
        chk("rd0_ack",    bus.P0_ACK, 1);
        chk("rd0_rdata",  bus.P0_RDATA, 16'd7);
        chk("rd0_err",    bus.P0_ERR, 0);
        chk("rd0_p1ack",  bus.P1_ACK, 0);
        chk("rd0_memread_clr", bus.MemRead, 0);
        tick();
        chk("rd0_ack_drop", bus.P0_ACK, 0);
        chk("rd0_idle",     bus.BUSY, 0);
        chk("rd0_hold",     bus.P0_RDATA, 16'd7);

        // P1 writes 1234 to addr 97, then P0 reads it back.
        wr_cnt = 0;
        bus.P1_REQ = 1; bus.P1_WE = 1; bus.P1_ADDR = 16'd97; bus.P1_WDATA = 16'd1234;
        tick();
        chk("wr_memwrite", bus.MemWrite, 1);
        chk("wr_memread",  bus.MemRead, 0);
        chk("wr_datain",   bus.DataIn, 16'd1234);
        bus.P1_REQ = 0;
        tick();
        chk("wr_ack", bus.P1_ACK, 1);
        chk("wr_memwrite_clr", bus.MemWrite, 0);
        tick();
        chk("wr_once", wr_cnt, 1);
        chk("wr_mem97", mem[97], 16'd1234);
        bus.P0_REQ = 1; bus.P0_WE = 0; bus.P0_ADDR = 16'd97;
        tick();
        bus.P0_REQ = 0;
        tick();
        chk("rb_ack",   bus.P0_ACK, 1);
        chk("rb_rdata", bus.P0_RDATA, 16'd1234);
        tick();

        // Both request continuously; P0 was granted last, so P1 leads.
        bus.P0_REQ = 1; bus.P0_WE = 0; bus.P0_ADDR = 16'd9;
        bus.P1_REQ = 1; bus.P1_WE = 0; bus.P1_ADDR = 16'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            chk($sformatf("rr_ack%0d", k), {bus.P1_ACK, bus.P0_ACK}, rr_exp[k]);
            if (rr_exp[k][1]) chk($sformatf("rr_rdata%0d", k), bus.P1_RDATA, 16'd7);
            else              chk($sformatf("rr_rdata%0d", k), bus.P0_RDATA, 16'd15);
            tick();
        end
        bus.P0_REQ = 0; bus.P1_REQ = 0;

        // Out-of-range read, then out-of-range write aliasing addr 0.
        rd_cnt = 0; wr_cnt = 0;
        bus.P0_REQ = 1; bus.P0_WE = 0; bus.P0_ADDR = 16'h0100;
        tick();
        chk("oor_rd_busy",    bus.BUSY, 1);
        chk("oor_rd_memread", bus.MemRead, 0);
        bus.P0_REQ = 0;
        tick();
        chk("oor_rd_ackerr", {bus.P0_ACK, bus.P0_ERR}, 2'b11);
        chk("oor_rd_rdata",  bus.P0_RDATA, 16'h0000);
        tick();
        chk("oor_rd_errdrop", bus.P0_ERR, 0);
        bus.P0_REQ = 1; bus.P0_WE = 1; bus.P0_ADDR = 16'h0100; bus.P0_WDATA = 16'd5;
        tick();
        chk("oor_wr_memwrite", bus.MemWrite, 0);
        bus.P0_REQ = 0;
        tick();
        chk("oor_wr_ackerr", {bus.P0_ACK, bus.P0_ERR}, 2'b11);
        tick();
        chk("oor_no_read",  rd_cnt, 0);
        chk("oor_no_write", wr_cnt, 0);
        chk("oor_mem0",     mem[0], 16'd7);

        // Reset lands inside ACCESS of a P1 write: write is lost, no ACK.
        bus.P1_REQ = 1; bus.P1_WE = 1; bus.P1_ADDR = 16'd9; bus.P1_WDATA = 16'd99;
        tick();
        chk("rstw_memwrite", bus.MemWrite, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rstw_drop", bus.MemWrite, 0);
        chk("rstw_idle", bus.BUSY, 0);
        bus.P1_REQ = 0;
        tick();
        chk("rstw_mem9",  mem[9], 16'd15);
        chk("rstw_noack", {bus.P1_ACK, bus.P0_ACK}, 0);
        RST_N = 1'b1;

        // Back-to-back P0 requests: ACKs three cycles apart.
        bus.P0_REQ = 1; bus.P0_WE = 0; bus.P0_ADDR = 16'd9;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (bus.P0_ACK) ack_t.push_back(c);
        end
        bus.P0_REQ = 0;
        chk("b2b_count", ack_t.size(), 3);
        chk("b2b_first", (ack_t.size() > 0) ? ack_t[0] : -1, 2);
        chk("b2b_gap1",  (ack_t.size() > 1) ? ack_t[1] - ack_t[0] : -1, 3);
        chk("b2b_gap2",  (ack_t.size() > 2) ? ack_t[2] - ack_t[1] : -1, 3);
        tick();
        tick();

        // Fixed priority: P1 starves while P0 keeps requesting.
        n0 = 0; n1 = 0;
        bfx.P0_REQ = 1; bfx.P1_REQ = 1;
        bfx.P0_ADDR = 16'd1; bfx.P1_ADDR = 16'd2;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bfx.P0_ACK) n0++;
            if (bfx.P1_ACK) n1++;
        end
        chk("fx_p0_acks", n0, 4);
        chk("fx_p1_starved", n1, 0);
        bfx.P0_REQ = 0;
        n1 = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bfx.P1_ACK) n1++;
        end
        bfx.P1_REQ = 0;
        chk("fx_p1_served", n1, 1);
        chk("fx_p1_rdata",  bfx.P1_RDATA, 16'h00AA);

        chk("never_rd_and_wr", both_hi, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
